// File: rtl/rr_mux_arbiter_pkg.sv
// Shared defaults, FSM encoding and helpers for the round-robin mux arbiter.
// Everything here is imported by the picker and the top level.
package rr_mux_arbiter_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_SEL_W    = 3;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Wide one-hot; callers truncate to their own N (N <= 64).
    function automatic logic [63:0] onehot(input logic [31:0] idx);
        return 64'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first set req bit scanning
// ptr, ptr+1, ... wrapping modulo N.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] j;

    // Scan from the far end so the smallest offset from ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a built-in N:1 single-bit mux,
// with a maximum hold time per grant so no requester starves the others.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     in,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             y,
    output logic             switch_pulse,
    output logic             state_o
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_e            state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [HOLD_W-1:0] hold_q;
    logic [N-1:0]      gnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic              valid_q;
    logic              switch_q;

    logic [SEL_W-1:0]  pick_ptr_d;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              hold_d;

    // In GRANT the picker only matters on release, where the scan starts
    // just past the current owner so that owner is naturally last.
    assign pick_ptr_d = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
    assign hold_d     = req[sel_q] && (hold_q < HOLD_W'(MAX_HOLD - 1));

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr_d),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    switch_q <= 1'b0;
                    if (pick_found) begin
                        gnt_q    <= N'(onehot(32'(pick_idx)));
                        sel_q    <= pick_idx;
                        valid_q  <= 1'b1;
                        switch_q <= 1'b1;
                        hold_q   <= '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_d) begin
                        hold_q   <= hold_q + HOLD_W'(1);
                        switch_q <= 1'b0;
                    end else begin
                        ptr_q <= sel_q + SEL_W'(1);
                        if (pick_found) begin
                            gnt_q    <= N'(onehot(32'(pick_idx)));
                            sel_q    <= pick_idx;
                            switch_q <= 1'b1;
                            hold_q   <= '0;
                        end else begin
                            gnt_q    <= '0;
                            valid_q  <= 1'b0;
                            switch_q <= 1'b0;
                            hold_q   <= '0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // req is level-held by each requester until it is granted; gnt, sel and
    // valid are registered, and y is the only combinational output.
    assign gnt          = gnt_q;
    assign sel          = sel_q;
    assign valid        = valid_q;
    assign switch_pulse = switch_q;
    assign state_o      = state_q;
    assign y            = valid_q & in[sel_q];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and constrained-random bench for rr_mux_arbiter.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_rr_mux_arbiter;

  localparam int N = 8;
  localparam int MAX_HOLD = 4;
  localparam int MAX_WAIT = (N - 1) * MAX_HOLD + 1;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req;
  logic [7:0]   din;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic         valid;
  logic         y;
  logic         switch_pulse;
  logic         state_o;

  int n_vec;
  int n_err;

  rr_mux_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .in           (din),
    .gnt          (gnt),
    .sel          (sel),
    .valid        (valid),
    .y            (y),
    .switch_pulse (switch_pulse),
    .state_o      (state_o)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // bundle layout: {state, gnt[7:0], sel[2:0], valid, y, switch_pulse}
  task automatic test_reset();
    logic [14:0] got, exp;
    rst_n = 1'b0;
    req   = '0;
    din   = 8'b1010_1010;
    repeat (2) @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_idle: got %h want %h", got, exp); end
    rst_n = 1'b1;
    req   = 8'hFF;
    @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_first_grant: got %h want %h", got, exp); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_async_drop: got %h want %h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_regrant_idx0: got %h want %h", got, exp); end
  endtask

  task automatic test_single();
    logic [14:0] got, exp;
    do_reset();
    req = 8'b0000_0100;
    din = 8'b1010_1010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = {state_o, gnt, sel, valid, y, switch_pulse};
      exp = {1'b1, 8'b0000_0100, 3'd2, 1'b1, 1'b0, (c % MAX_HOLD) == 0};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL single_c%0d: got %h want %h", c, got, exp); end
    end
  endtask

  task automatic test_round_robin();
    logic [14:0] got, exp;
    logic [2:0]  idx;
    do_reset();
    req = 8'hFF;
    din = 8'b1010_1010;
    for (int c = 0; c < 9 * MAX_HOLD; c++) begin
      @(negedge clk);
      idx = 3'((c / MAX_HOLD) % N);
      got = {state_o, gnt, sel, valid, y, switch_pulse};
      exp = {1'b1, 8'b1 << idx, idx, 1'b1, idx[0], (c % MAX_HOLD) == 0};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL rr_c%0d: got %h want %h", c, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] got, exp;
    logic [11:0] got_s, exp_s;
    do_reset();
    req = 8'b1000_0001;
    din = 8'b1000_0000;
    @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL b2b_grant0: got %h want %h", got, exp); end
    @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL b2b_hold0: got %h want %h", got, exp); end
    req = 8'b1000_0000;
    @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL b2b_switch7: got %h want %h", got, exp); end
    req = 8'h00;
    @(negedge clk);
    got_s = {state_o, gnt, valid, y, switch_pulse};
    exp_s = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (got_s !== exp_s) begin n_err++; $display("FAIL b2b_idle: got %h want %h", got_s, exp_s); end
  endtask

  task automatic test_wrap();
    logic [14:0] got, exp;
    logic [2:0]  order [4];
    logic [2:0]  idx;
    order[0] = 3'd7; order[1] = 3'd0; order[2] = 3'd1; order[3] = 3'd7;
    do_reset();
    req = 8'b0100_0000;
    @(negedge clk);
    got = {state_o, gnt, sel, valid, y, switch_pulse};
    exp = {1'b1, 8'h40, 3'd6, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL wrap_setup: got %h want %h", got, exp); end
    req = 8'h00;
    @(negedge clk);
    req = 8'b1000_0011;
    for (int c = 0; c < 4 * MAX_HOLD; c++) begin
      @(negedge clk);
      idx = order[c / MAX_HOLD];
      got = {state_o, gnt, sel, valid, y, switch_pulse};
      exp = {1'b1, 8'b1 << idx, idx, 1'b1, 1'b0, (c % MAX_HOLD) == 0};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL wrap_c%0d: got %h want %h", c, got, exp); end
    end
  endtask

  task automatic test_random();
    int   wait_c [N];
    int   run;
    int   worst;
    logic [7:0] nreq;
    logic onehot_ok;
    do_reset();
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    run = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      onehot_ok = (gnt == 8'h00) || ((gnt & (gnt - 8'd1)) == 8'h00);
      n_vec++;
      if (onehot_ok !== 1'b1) begin n_err++; $display("FAIL rand_onehot_c%0d: gnt %b want 0 or one-hot", c, gnt); end
      n_vec++;
      if (gnt[sel] !== valid) begin n_err++; $display("FAIL rand_gnt_sel_c%0d: gnt[sel] %b want valid %b", c, gnt[sel], valid); end
      if (!valid) run = 0;
      else if (switch_pulse) run = 1;
      else run++;
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > worst) worst = wait_c[i];
      end
      n_vec++;
      if (run > MAX_HOLD) begin n_err++; $display("FAIL rand_hold_c%0d: held %0d want <= %0d", c, run, MAX_HOLD); end
      n_vec++;
      if (worst > MAX_WAIT) begin n_err++; $display("FAIL rand_wait_c%0d: waited %0d want <= %0d", c, worst, MAX_WAIT); end
      nreq = req;
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i] && $urandom_range(0, 2) == 0) nreq[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) nreq[i] = 1'b1;
      end
      req = nreq;
      din = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
